// File: rtl/bnn_uart_link.sv
// bnn_uart_link: full-duplex UART link with RTS/CTS flow control for the BNN controller.
// RX frames land in a show-ahead FIFO drained over valid/ready; TX sends one word per handshake.
// Optional feature macro: BNN_UART_PARITY_EN adds one even-parity bit after the data bits.
module bnn_uart_link #(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned CTS_HEADROOM = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              uart_rx,
    input  logic              uart_rts_n,
    output logic              uart_tx,
    output logic              uart_cts_n,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              rx_err,
    output logic              rx_overflow
);

    localparam int unsigned CNT_W     = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W     = $clog2(DATA_W);
    localparam int unsigned ADDR_W    = $clog2(FIFO_DEPTH);
    localparam int unsigned FCNT_W    = ADDR_W + 1;
    localparam int unsigned CTS_LEVEL = FIFO_DEPTH - CTS_HEADROOM;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef BNN_UART_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } uart_state_t;

    // ---------------- synchronisers ----------------
    logic rx_meta, rx_sync, rx_prev;
    logic rts_meta, rts_sync;

    // Two-flop synchronisers for the asynchronous line inputs, plus edge history for RX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            rts_meta <= 1'b1;
            rts_sync <= 1'b1;
        end else begin
            rx_meta  <= uart_rx;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            rts_meta <= uart_rts_n;
            rts_sync <= rts_meta;
        end
    end

    // ---------------- RX deserialiser ----------------
    uart_state_t       rx_state, rx_state_n;
    logic [CNT_W-1:0]  rx_cnt, rx_cnt_n;
    logic [BIT_W-1:0]  rx_bit, rx_bit_n;
    logic [DATA_W-1:0] rx_shift, rx_shift_n;
    logic              rx_par_ok_c;
    logic              rx_push_c;
    logic              rx_frame_err_c;
`ifdef BNN_UART_PARITY_EN
    logic              rx_par, rx_par_n;
    assign rx_par_ok_c = ~(^rx_shift ^ rx_par);
`else
    assign rx_par_ok_c = 1'b1;
`endif

    // RX state register and bit-timing datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_err   <= 1'b0;
`ifdef BNN_UART_PARITY_EN
            rx_par   <= 1'b0;
`endif
        end else begin
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
            rx_err   <= rx_frame_err_c;
`ifdef BNN_UART_PARITY_EN
            rx_par   <= rx_par_n;
`endif
        end
    end

    // RX next-state: start detect, mid-bit sampling, stop/parity evaluation
    always_comb begin
        rx_state_n     = rx_state;
        rx_cnt_n       = rx_cnt;
        rx_bit_n       = rx_bit;
        rx_shift_n     = rx_shift;
        rx_push_c      = 1'b0;
        rx_frame_err_c = 1'b0;
`ifdef BNN_UART_PARITY_EN
        rx_par_n       = rx_par;
`endif
        case (rx_state)
            S_IDLE: begin
                if (rx_prev && !rx_sync) begin
                    rx_state_n = S_START;
                    rx_cnt_n   = CNT_W'(CLKS_PER_BIT / 2);
                end
            end
            S_START: begin
                if (rx_cnt != '0) begin
                    rx_cnt_n = rx_cnt - CNT_W'(1);
                end else if (rx_sync) begin
                    rx_state_n = S_IDLE;
                end else begin
                    rx_state_n = S_DATA;
                    rx_cnt_n   = CNT_W'(CLKS_PER_BIT - 1);
                    rx_bit_n   = '0;
                end
            end
            S_DATA: begin
                if (rx_cnt != '0) begin
                    rx_cnt_n = rx_cnt - CNT_W'(1);
                end else begin
                    rx_shift_n = {rx_sync, rx_shift[DATA_W-1:1]};
                    rx_cnt_n   = CNT_W'(CLKS_PER_BIT - 1);
                    if (rx_bit == BIT_W'(DATA_W - 1)) begin
`ifdef BNN_UART_PARITY_EN
                        rx_state_n = S_PARITY;
`else
                        rx_state_n = S_STOP;
`endif
                    end else begin
                        rx_bit_n = rx_bit + BIT_W'(1);
                    end
                end
            end
`ifdef BNN_UART_PARITY_EN
            S_PARITY: begin
                if (rx_cnt != '0) begin
                    rx_cnt_n = rx_cnt - CNT_W'(1);
                end else begin
                    rx_par_n   = rx_sync;
                    rx_state_n = S_STOP;
                    rx_cnt_n   = CNT_W'(CLKS_PER_BIT - 1);
                end
            end
`endif
            S_STOP: begin
                if (rx_cnt != '0) begin
                    rx_cnt_n = rx_cnt - CNT_W'(1);
                end else begin
                    rx_state_n = S_IDLE;
                    if (rx_sync && rx_par_ok_c) begin
                        rx_push_c = 1'b1;
                    end else begin
                        rx_frame_err_c = 1'b1;
                    end
                end
            end
            default: rx_state_n = S_IDLE;
        endcase
    end

    // ---------------- RX FIFO ----------------
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr, rd_ptr_n;
    logic [FCNT_W-1:0] fifo_cnt, fifo_cnt_n;
    logic              pop_c, full_c, push_ok_c, ovf_c;
    logic [DATA_W-1:0] head_n;

    // FIFO control: simultaneous push/pop always accepted, full push alone is dropped
    always_comb begin
        pop_c     = rx_valid & rx_ready;
        full_c    = (fifo_cnt == FCNT_W'(FIFO_DEPTH));
        push_ok_c = rx_push_c & (~full_c | pop_c);
        ovf_c     = rx_push_c & full_c & ~pop_c;
        rd_ptr_n  = pop_c ? rd_ptr + ADDR_W'(1) : rd_ptr;
        fifo_cnt_n = fifo_cnt;
        if (push_ok_c && !pop_c) begin
            fifo_cnt_n = fifo_cnt + FCNT_W'(1);
        end else if (!push_ok_c && pop_c) begin
            fifo_cnt_n = fifo_cnt - FCNT_W'(1);
        end
        // a word written into the next head slot bypasses the array read
        if (push_ok_c && (wr_ptr == rd_ptr_n)) begin
            head_n = rx_shift;
        end else begin
            head_n = mem[rd_ptr_n];
        end
    end

    // FIFO storage, pointers, registered head word and flow-control outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            rx_overflow <= 1'b0;
            uart_cts_n  <= 1'b1;
        end else begin
            if (push_ok_c) begin
                mem[wr_ptr] <= rx_shift;
                wr_ptr      <= wr_ptr + ADDR_W'(1);
            end
            rd_ptr      <= rd_ptr_n;
            fifo_cnt    <= fifo_cnt_n;
            rx_data     <= head_n;
            rx_valid    <= (fifo_cnt_n != '0);
            rx_overflow <= ovf_c;
            uart_cts_n  <= (fifo_cnt >= FCNT_W'(CTS_LEVEL));
        end
    end

    // ---------------- TX serialiser ----------------
    uart_state_t       tx_state, tx_state_n;
    logic [CNT_W-1:0]  tx_cnt, tx_cnt_n;
    logic [BIT_W-1:0]  tx_bit, tx_bit_n;
    logic [DATA_W-1:0] tx_shift, tx_shift_n;
    logic              tx_line_n;
    logic              tx_ready_n;
    logic              tx_hs_c;
`ifdef BNN_UART_PARITY_EN
    logic              tx_par, tx_par_n;
`endif

    // TX state register, line driver and ready flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            uart_tx  <= 1'b1;
            tx_ready <= 1'b0;
`ifdef BNN_UART_PARITY_EN
            tx_par   <= 1'b0;
`endif
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
            uart_tx  <= tx_line_n;
            tx_ready <= tx_ready_n;
`ifdef BNN_UART_PARITY_EN
            tx_par   <= tx_par_n;
`endif
        end
    end

    // TX next-state: latch on handshake, then start/data/[parity]/stop bit timing
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_line_n  = uart_tx;
        tx_hs_c    = tx_valid & tx_ready;
`ifdef BNN_UART_PARITY_EN
        tx_par_n   = tx_par;
`endif
        case (tx_state)
            S_IDLE: begin
                tx_line_n = 1'b1;
                if (tx_hs_c) begin
                    tx_shift_n = tx_data;
                    tx_state_n = S_START;
                    tx_cnt_n   = CNT_W'(CLKS_PER_BIT - 1);
                    tx_line_n  = 1'b0;
`ifdef BNN_UART_PARITY_EN
                    tx_par_n   = ^tx_data;
`endif
                end
            end
            S_START: begin
                if (tx_cnt != '0) begin
                    tx_cnt_n = tx_cnt - CNT_W'(1);
                end else begin
                    tx_state_n = S_DATA;
                    tx_cnt_n   = CNT_W'(CLKS_PER_BIT - 1);
                    tx_bit_n   = '0;
                    tx_line_n  = tx_shift[0];
                end
            end
            S_DATA: begin
                if (tx_cnt != '0) begin
                    tx_cnt_n = tx_cnt - CNT_W'(1);
                end else begin
                    tx_cnt_n = CNT_W'(CLKS_PER_BIT - 1);
                    if (tx_bit == BIT_W'(DATA_W - 1)) begin
`ifdef BNN_UART_PARITY_EN
                        tx_state_n = S_PARITY;
                        tx_line_n  = tx_par;
`else
                        tx_state_n = S_STOP;
                        tx_line_n  = 1'b1;
`endif
                    end else begin
                        tx_bit_n   = tx_bit + BIT_W'(1);
                        tx_shift_n = tx_shift >> 1;
                        tx_line_n  = tx_shift[1];
                    end
                end
            end
`ifdef BNN_UART_PARITY_EN
            S_PARITY: begin
                if (tx_cnt != '0) begin
                    tx_cnt_n = tx_cnt - CNT_W'(1);
                end else begin
                    tx_state_n = S_STOP;
                    tx_cnt_n   = CNT_W'(CLKS_PER_BIT - 1);
                    tx_line_n  = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (tx_cnt != '0) begin
                    tx_cnt_n = tx_cnt - CNT_W'(1);
                end else begin
                    tx_state_n = S_IDLE;
                    tx_line_n  = 1'b1;
                end
            end
            default: begin
                tx_state_n = S_IDLE;
                tx_line_n  = 1'b1;
            end
        endcase
        // RTS only matters when a new frame could start
        tx_ready_n = (tx_state_n == S_IDLE) && !rts_sync;
    end

endmodule
